// File: rtl/xorshift_stream_checker.sv
// Receive-side checker for 32-bit XorShift128 streams: acquires generator state
// from four received words, then predicts and compares every following beat.
module xorshift_stream_checker #(
  parameter int unsigned MAX_MISS = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear_counts,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      expected
);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  localparam logic [7:0]       MISS_LIM = 8'(MAX_MISS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t      state, state_nx;
  logic [31:0] x0, x1, x2, x3;
  logic [31:0] t_a, t_b;
  logic [1:0]  acq_cnt;
  logic [7:0]  miss_cnt;
  logic        beat_locked, mismatch, miss_hit;

  // Prediction for the next beat: one XorShift128 step of the current state
  always_comb begin
    t_a      = x3 ^ (x3 << 11);
    t_b      = t_a ^ (t_a >> 8);
    expected = t_b ^ x0 ^ (x0 >> 19);
  end

  // Beat classification and next-state selection
  always_comb begin
    beat_locked = (state == LOCKED) && in_valid;
    mismatch    = beat_locked && (in_data != expected);
    miss_hit    = mismatch && ((miss_cnt + 8'd1) == MISS_LIM);
    state_nx    = state;
    unique case (state)
      ACQUIRE: if (in_valid && acq_cnt == 2'd3) state_nx = LOCKED;
      LOCKED:  if (miss_hit)                    state_nx = ACQUIRE;
      default: state_nx = ACQUIRE;
    endcase
  end

  assign locked = (state == LOCKED);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ACQUIRE;
    else       state <= state_nx;
  end

  // Generator state, acquire/miss tracking and error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      x0          <= '0;
      x1          <= '0;
      x2          <= '0;
      x3          <= '0;
      acq_cnt     <= '0;
      miss_cnt    <= '0;
      error_pulse <= 1'b0;
    end else begin
      error_pulse <= mismatch;
      if (in_valid) begin
        x3 <= x2;
        x2 <= x1;
        x1 <= x0;
        if (state == ACQUIRE) begin
          x0      <= in_data;
          acq_cnt <= acq_cnt + 2'd1;
        end else begin
          // Generator advances on the prediction, never on the received word
          x0       <= expected;
          acq_cnt  <= '0;
          miss_cnt <= (mismatch && !miss_hit) ? miss_cnt + 8'd1 : '0;
        end
      end
    end
  end

  // Saturating match/mismatch counters; clear takes priority over counting
  always_ff @(posedge clock) begin
    if (reset || clear_counts) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (beat_locked) begin
      if (word_count != CNT_MAX) word_count <= word_count + CNT_W'(1);
      if (mismatch && err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Self-checking bench for xorshift_stream_checker against a behavioural model.
module tb_xorshift_stream_checker;

  localparam int MAXM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, clear_counts = 1'b0;
  logic [31:0] in_data = '0;
  logic        locked, error_pulse;
  logic [31:0] err_count, word_count, expected;

  logic        v4 = 1'b0, clr4 = 1'b0;
  logic [31:0] d4 = '0;
  logic        locked4, pulse4;
  logic [3:0]  err4, words4;
  logic [31:0] exp4;

  always #5 clock = ~clock;

  xorshift_stream_checker #(.MAX_MISS(MAXM), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_counts(clear_counts), .locked(locked), .error_pulse(error_pulse),
    .err_count(err_count), .word_count(word_count), .expected(expected));

  xorshift_stream_checker #(.MAX_MISS(255), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(v4), .in_data(d4),
    .clear_counts(clr4), .locked(locked4), .error_pulse(pulse4),
    .err_count(err4), .word_count(words4), .expected(exp4));

  int n_assert = 0;
  int n_fail   = 0;
  int pulses_seen;

  logic [31:0] stream [104];
  logic [31:0] mask   [104];

  // Behavioural model: acquired history, lock flag, counts
  bit          m_locked;
  int          m_acq, m_miss;
  logic [31:0] hist [4];   // hist[0] = newest word
  logic [31:0] m_err, m_words;
  bit          m_pulse;

  function automatic logic [31:0] xs_next(logic [31:0] x, logic [31:0] w);
    logic [31:0] t;
    t = x ^ (x << 11);
    t = t ^ (t >> 8);
    return w ^ (w >> 19) ^ t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_update(input bit rst, input bit v, input logic [31:0] d, input bit clr);
    logic [31:0] pred;
    bit bad;
    m_pulse = 0;
    if (rst) begin
      m_locked = 0; m_acq = 0; m_miss = 0; m_err = 0; m_words = 0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
      return;
    end
    if (v && !m_locked) begin
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = d;
      m_acq++;
      if (m_acq == 4) begin m_locked = 1; m_acq = 0; end
    end else if (v) begin
      pred = xs_next(hist[3], hist[0]);
      bad  = (d != pred);
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pred;
      if (!clr) begin
        if (m_words != 32'hFFFF_FFFF) m_words++;
        if (bad && m_err != 32'hFFFF_FFFF) m_err++;
      end
      m_pulse = bad;
      m_miss  = bad ? m_miss + 1 : 0;
      if (m_miss == MAXM) begin m_locked = 0; m_miss = 0; m_acq = 0; end
    end
    if (clr) begin m_err = 0; m_words = 0; end
  endtask

  task automatic step(input bit rst, input bit v, input logic [31:0] d, input bit clr);
    reset = rst; in_valid = v; in_data = d; clear_counts = clr;
    v4 = 1'b0; clr4 = 1'b0;
    if (m_locked) chk("expected", expected, xs_next(hist[3], hist[0]));
    @(posedge clock);
    model_update(rst, v, d, clr);
    #1;
    pulses_seen += int'(error_pulse);
    chk("locked", 32'(locked), 32'(m_locked));
    chk("error_pulse", 32'(error_pulse), 32'(m_pulse));
    chk("err_count", err_count, m_err);
    chk("word_count", word_count, m_words);
  endtask

  task automatic feed(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) step(0, 0, $urandom, 0);
      end
      step(0, 1, stream[i] ^ mask[i], 0);
    end
  endtask

  task automatic restart();
    for (int i = 0; i < 104; i++) mask[i] = '0;
    pulses_seen = 0;
    step(1, 0, '0, 0);
  endtask

  task automatic step4(input bit v, input logic [31:0] d, input bit clr);
    in_valid = 1'b0; clear_counts = 1'b0; reset = 1'b0;
    v4 = v; d4 = d; clr4 = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] x, y, z, w, t;
    x = 32'd12345678; y = 32'd36243669; z = 32'd521288629; w = 32'd1481231;
    for (int i = 0; i < 104; i++) begin
      t = xs_next(x, w);
      x = y; y = z; z = w; w = t;
      stream[i] = t;
    end

    // Reset state
    restart();
    step(1, 1, 32'hDEAD_BEEF, 1);
    chk("reset_expected", expected, 32'h0);
    chk("reset_pulse4", 32'(pulse4), 32'h0);

    // Clean stream
    feed(0, 2, 0);
    chk("not_locked_b3", 32'(locked), 32'h0);
    feed(3, 3, 0);
    chk("locked_after_b4", 32'(locked), 32'h1);
    feed(4, 103, 0);
    chk("clean_words", word_count, 32'd100);
    chk("clean_errs", err_count, 32'd0);
    chk("clean_pulses", 32'(pulses_seen), 32'd0);

    // Single bit flip on beat 50
    restart();
    mask[49] = 32'h1;
    feed(0, 49, 0);
    chk("flip_pulse_b50", 32'(error_pulse), 32'h1);
    feed(50, 103, 0);
    chk("flip_errs", err_count, 32'd1);
    chk("flip_words", word_count, 32'd100);
    chk("flip_pulses", 32'(pulses_seen), 32'd1);

    // Four consecutive corrupt beats force re-acquisition
    restart();
    for (int i = 29; i <= 32; i++) mask[i] = 32'hA5A5_0F0F;
    feed(0, 32, 0);
    chk("loss_locked", 32'(locked), 32'h0);
    chk("loss_errs", err_count, 32'd4);
    chk("loss_pulse", 32'(error_pulse), 32'h1);
    feed(33, 36, 0);
    chk("relock", 32'(locked), 32'h1);
    feed(37, 103, 0);
    chk("loss_final_errs", err_count, 32'd4);

    // Random idle gaps
    restart();
    feed(0, 103, 1);
    chk("gaps_words", word_count, 32'd100);
    chk("gaps_errs", err_count, 32'd0);

    // Reset mid-stream, then re-acquire; finally clear coinciding with a bad beat
    restart();
    feed(0, 59, 0);
    step(1, 1, stream[60], 0);
    chk("midreset_locked", 32'(locked), 32'h0);
    chk("midreset_words", word_count, 32'd0);
    feed(61, 103, 1);
    chk("midreset_words_end", word_count, 32'd39);
    chk("midreset_errs_end", err_count, 32'd0);
    step(0, 1, ~xs_next(hist[3], hist[0]), 1);
    chk("clear_beat_pulse", 32'(error_pulse), 32'h1);
    chk("clear_beat_words", word_count, 32'd0);

    // Narrow counters saturate on a constant-zero stream
    step(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) step4(1, stream[i], 0);
    chk("c4_locked", 32'(locked4), 32'h1);
    for (int i = 1; i <= 20; i++) begin
      step4(1, 32'h0, 0);
      chk("c4_errs", 32'(err4), (i < 15) ? i : 15);
      chk("c4_words", 32'(words4), (i < 15) ? i : 15);
      chk("c4_pulse", 32'(pulse4), 32'h1);
    end
    chk("c4_still_locked", 32'(locked4), 32'h1);
    step4(0, 32'h0, 1);
    chk("c4_clear_errs", 32'(err4), 32'h0);
    chk("c4_clear_words", 32'(words4), 32'h0);
    chk("c4_clear_locked", 32'(locked4), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xorshift_stream_checker.md
Name: xorshift_stream_checker

Overview:
- Receive-side checker for 32-bit XorShift128 pseudo-random streams produced by the on-chip generators. It lets tests verify data paths (memories, FIFOs, links) end to end without a golden-data store.
- It self-synchronises by loading its generator state from four consecutive received words. It then predicts every following word, compares each beat, and counts matches and mismatches.
- It drops lock and re-acquires after a run of consecutive mismatches.

Parameters:
- MAX_MISS, 4, number of consecutive mismatches in LOCKED that forces re-acquisition (legal range 1..255).
- CNT_W, 32, width of the saturating err_count and word_count counters (legal range 4..32).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_data on this cycle; one beat per cycle when high.
- in_data  input  32  received stream word.
- clear_counts  input  1  synchronous clear of err_count and word_count; lock state is unaffected.
- locked  output  1  high while in the LOCKED state.
- error_pulse  output  1  one-cycle pulse, registered, for each mismatching beat in LOCKED.
- err_count  output  CNT_W  total mismatches in LOCKED; saturates at all-ones.
- word_count  output  CNT_W  total beats compared in LOCKED, matched or not; saturates at all-ones.
- expected  output  32  the word predicted for the next valid beat; valid only while locked.

Behaviour:
- Generator step, which must match the generator exactly:
  - state is (x0, x1, x2, x3); t = x3; s = x0.
  - x3 <= x2; x2 <= x1; x1 <= s.
  - t ^= t << 11; t ^= t >> 8.
  - x0 <= t ^ s ^ (s >> 19).
  - All 32-bit shifts are logical. The predicted word is the new x0.
- Reset: state ACQUIRE, acquire count 0, miss count 0, locked=0, error_pulse=0, err_count=0, word_count=0, x0..x3=0, expected=0. Reset overrides every other input.
- ACQUIRE:
  - Each valid beat shifts the word into the state: x3 <= x2, x2 <= x1, x1 <= x0, x0 <= in_data. The acquire count then increments.
  - On the 4th valid beat, move to LOCKED and set locked=1 on the following cycle.
  - expected then already shows the step of (x0..x3), i.e. the prediction for beat 5.
  - No comparisons and no counter updates occur in ACQUIRE.
- LOCKED, on each valid beat:
  - Compare in_data with expected; the generator steps regardless of the result.
  - word_count increments.
  - On a mismatch: err_count increments, error_pulse=1 next cycle, miss count increments.
  - On a match: miss count clears.
  - When the miss count reaches MAX_MISS on a beat, move to ACQUIRE next cycle: locked=0, acquire count 0, miss count 0. That beat is still counted.
- Idle cycles (in_valid=0) change no state or counters, in either state; error_pulse=0.
- Saturation: err_count and word_count hold at 2^CNT_W-1 and never wrap.
- clear_counts:
  - Zeroes both counters next cycle.
  - If it coincides with a counting beat, the clear wins and that beat is not counted. Its error_pulse still fires.
- Latency: error_pulse and the counter updates appear 1 cycle after the beat. locked rises 1 cycle after the 4th acquire beat.
- The error pulse for the beat that causes loss of lock is asserted in the same cycle locked falls.
- All-zero state: if the acquired words give x0..x3 = 0, the generator stays at 0; this is legal behaviour. The source must never emit four zero words.

Test Plan:
- Reset, then feed a reference XorShift128 stream (seeds 12345678, 36243669, 521288629, 1481231) with in_valid=1 for 104 beats. Required: locked=1 from the cycle after beat 4; word_count=100, err_count=0, no error_pulse.
- Same stream, with bit 0 of beat 50 flipped. Required: exactly one error_pulse, 1 cycle after beat 50; err_count=1, word_count=100; locked stays 1 throughout.
- Corrupt beats 30..33 with MAX_MISS=4. Required: err_count=4 and locked=0 after beat 33. Feeding 4 more good beats re-locks with locked=1. Remaining beats match, so err_count stays 4.
- Random in_valid gaps with about 50% duty over the clean stream. Required: results identical to the first scenario; counters do not move on idle cycles.
- CNT_W=4 with a constant-zero stream after lock (20 mismatch beats, MAX_MISS=255). Required: err_count=15, word_count=15, held with no wrap. Asserting clear_counts then gives both 0.
- Assert reset while locked, mid-stream. Required: locked=0 and counters 0 on the next cycle. The checker re-locks from the next 4 beats and resumes with zero errors.
